// File: rtl/sprite_plotter.sv
// Rasterises one draw command (corner, colour, shape code) into row-major
// single-pixel writes for a 160x120 frame, clipping anything off-screen.
module sprite_plotter #(
   parameter int CELL_SIZE = 32,
   parameter int IND_SIZE  = 8,
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] startx,
   input  logic [6:0] starty,
   input  logic [2:0] color,
   input  logic [2:0] selector,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       done
);

   localparam int CW = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   dx_r, dx_s, dy_r, dy_s;
   logic [CW-1:0]   w_r, w_s, h_r, h_s;
   logic [7:0]      sx_r, sx_s;
   logic [6:0]      sy_r, sy_s;
   logic [2:0]      col_r, col_s;
   logic [7:0]      x_r, x_s;
   logic [6:0]      y_r, y_s;
   logic [2:0]      colour_r, colour_s;
   logic            plot_r, plot_s;
   logic            done_r, done_s;
   logic            emit_s;
   logic [2*CW-1:0] dim_s;
   logic [8:0]      sum_x_s;
   logic [7:0]      sum_y_s;

   // Shape code to {width, height}; a zero dimension marks an empty shape.
   function automatic logic [2*CW-1:0] shape_dims(input logic [2:0] sel);
      logic [2*CW-1:0] d;
      case (sel)
         3'b000:  d = {CW'(CELL_SIZE), CW'(CELL_SIZE)};
         3'b001:  d = {CW'(IND_SIZE), CW'(IND_SIZE)};
         3'b011:  d = {CW'(IND_SIZE), CW'(2)};
         3'b100:  d = {CW'(2), CW'(IND_SIZE)};
         default: d = '0;
      endcase
      return d;
   endfunction

   // Next-state, scan counters and the pixel presented on the following cycle
   always_comb begin
      state_s  = state_r;
      dx_s     = dx_r;
      dy_s     = dy_r;
      w_s      = w_r;
      h_s      = h_r;
      sx_s     = sx_r;
      sy_s     = sy_r;
      col_s    = col_r;
      x_s      = x_r;
      y_s      = y_r;
      colour_s = colour_r;
      plot_s   = 1'b0;
      done_s   = 1'b0;
      emit_s   = 1'b0;
      dim_s    = shape_dims(selector);

      case (state_r)
         IDLE: begin
            if (req_valid) begin
               sx_s  = startx;
               sy_s  = starty;
               col_s = color;
               w_s   = dim_s[2*CW-1:CW];
               h_s   = dim_s[CW-1:0];
               dx_s  = '0;
               dy_s  = '0;
               if ((w_s == '0) || (h_s == '0)) begin
                  state_s = DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s = SCAN;
                  emit_s  = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SCAN: begin
            if ((dx_r == w_r - CW'(1)) && (dy_r == h_r - CW'(1))) begin
               state_s = DONE;
               done_s  = 1'b1;
               dx_s    = '0;
               dy_s    = '0;
            end else begin
               emit_s = 1'b1;
               if (dx_r == w_r - CW'(1)) begin
                  dx_s = '0;
                  dy_s = dy_r + CW'(1);
               end else begin
                  dx_s = dx_r + CW'(1);
               end
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      // One extra bit on each sum so off-screen pixels can be recognised
      sum_x_s = {1'b0, sx_s} + 9'(dx_s);
      sum_y_s = {1'b0, sy_s} + 8'(dy_s);
      if (emit_s) begin
         x_s      = sum_x_s[7:0];
         y_s      = sum_y_s[6:0];
         colour_s = col_s;
         plot_s   = (sum_x_s < 9'(SCREEN_W)) && (sum_y_s < 8'(SCREEN_H));
      end else begin
         plot_s   = 1'b0;
      end
   end

   // State, latched command, counters and registered VGA outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r  <= IDLE;
         dx_r     <= '0;
         dy_r     <= '0;
         w_r      <= '0;
         h_r      <= '0;
         sx_r     <= 8'd0;
         sy_r     <= 7'd0;
         col_r    <= 3'd0;
         x_r      <= 8'd0;
         y_r      <= 7'd0;
         colour_r <= 3'd0;
         plot_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         dx_r     <= dx_s;
         dy_r     <= dy_s;
         w_r      <= w_s;
         h_r      <= h_s;
         sx_r     <= sx_s;
         sy_r     <= sy_s;
         col_r    <= col_s;
         x_r      <= x_s;
         y_r      <= y_s;
         colour_r <= colour_s;
         plot_r   <= plot_s;
         done_r   <= done_s;
      end
   end

   assign req_ready = (state_r == IDLE);
   assign x         = x_r;
   assign y         = y_r;
   assign colour    = colour_r;
   assign plot      = plot_r;
   assign done      = done_r;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: expected pixels are queued when a command
// is issued and popped as the plotter emits them.
module tb_sprite_plotter;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req_valid = 1'b0;
   logic [7:0] startx = 8'd0;
   logic [6:0] starty = 7'd0;
   logic [2:0] color = 3'd0;
   logic [2:0] selector = 3'd0;
   logic       req_ready;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       done;

   int          vec_cnt = 0;
   int          err_cnt = 0;
   int          plot_cnt = 0;
   logic [17:0] exp_q[$];
   logic [2:0]  sel_tab [13] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110,
                                 3'b111, 3'b001, 3'b011, 3'b100, 3'b000, 3'b001};

   always #5 clk = ~clk;

   sprite_plotter dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .startx    (startx),
      .starty    (starty),
      .color     (color),
      .selector  (selector),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vec_cnt++;
      assert (obs === expv) else begin
         err_cnt++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Pixel monitor: every plot pulse must match the head of the scoreboard
   always @(negedge clk) begin
      logic [17:0] want;
      if (resetn && plot) begin
         plot_cnt++;
         chk("plot_with_done", 32'(done), 32'd0);
         want = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
         chk("pixel_xyc", 32'({x, y, colour}), 32'(want));
      end
   end

   task automatic push_shape(input logic [7:0] sx, input logic [6:0] sy, input logic [2:0] col,
                             input int w, input int h, output int n);
      n = 0;
      for (int j = 0; j < h; j++) begin
         for (int i = 0; i < w; i++) begin
            if ((int'(sx) + i < 160) && (int'(sy) + j < 120)) begin
               exp_q.push_back({8'(int'(sx) + i), 7'(int'(sy) + j), col});
               n++;
            end
         end
      end
   endtask

   // Issues one command (entered just after a negedge, plotter idle) and checks it fully
   task automatic run_cmd(input logic [7:0] sx, input logic [6:0] sy, input logic [2:0] col,
                          input logic [2:0] sel, input bit hold, input bit churn);
      int w, h, n, cyc, dcyc;
      logic first_in;
      case (sel)
         3'b000:  begin w = 32; h = 32; end
         3'b001:  begin w = 8;  h = 8;  end
         3'b011:  begin w = 8;  h = 2;  end
         3'b100:  begin w = 2;  h = 8;  end
         default: begin w = 0;  h = 0;  end
      endcase
      exp_q.delete();
      push_shape(sx, sy, col, w, h, n);
      first_in = (w > 0) && (sx < 8'd160) && (sy < 7'd120);
      startx = sx;
      starty = sy;
      color = col;
      selector = sel;
      req_valid = 1'b1;
      plot_cnt = 0;
      chk("ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      cyc = 0;
      dcyc = 0;
      while (dcyc == 0 && cyc < 1100) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            chk("first_plot", 32'(plot), 32'(first_in));
            chk("ready_busy", 32'(req_ready), 32'd0);
         end
         if (done) begin
            dcyc = cyc;
         end else if (churn) begin
            startx = 8'($urandom);
            starty = 7'($urandom);
            color = 3'($urandom);
            selector = 3'($urandom);
         end
      end
      chk("done_cycle", 32'(dcyc), 32'(w * h + 1));
      chk("plot_count", 32'(plot_cnt), 32'(n));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("ready_back", 32'(req_ready), 32'd1);
      chk("done_single", 32'(done), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int n;
      #12;
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_colour", 32'(colour), 32'd0);
      chk("rst_plot", 32'(plot), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);

      run_cmd(8'd4,   7'd4,   3'b010, 3'b000, 1'b0, 1'b0);
      run_cmd(8'd145, 7'd70,  3'b001, 3'b001, 1'b0, 1'b0);
      run_cmd(8'd155, 7'd115, 3'b100, 3'b001, 1'b0, 1'b0);
      run_cmd(8'd145, 7'd90,  3'b011, 3'b011, 1'b0, 1'b0);
      run_cmd(8'd145, 7'd80,  3'b101, 3'b100, 1'b0, 1'b0);
      run_cmd(8'd20,  7'd20,  3'b111, 3'b111, 1'b0, 1'b0);
      run_cmd(8'd10,  7'd10,  3'b000, 3'b001, 1'b0, 1'b1);

      for (int k = 0; k < 13; k++) begin
         run_cmd(8'($urandom_range(0, 170)), 7'($urandom_range(0, 125)),
                 3'($urandom), sel_tab[k], 1'b1, 1'b1);
      end
      req_valid = 1'b0;

      // Abort a cell at its 300th pixel with an asynchronous reset
      exp_q.delete();
      push_shape(8'd4, 7'd4, 3'b110, 32, 32, n);
      startx = 8'd4;
      starty = 7'd4;
      color = 3'b110;
      selector = 3'b000;
      req_valid = 1'b1;
      plot_cnt = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (300) @(negedge clk);
      #1;
      chk("pre_reset_count", 32'(plot_cnt), 32'd300);
      #1;
      resetn = 1'b0;
      #1;
      chk("mid_rst_plot", 32'(plot), 32'd0);
      chk("mid_rst_x", 32'(x), 32'd0);
      chk("mid_rst_y", 32'(y), 32'd0);
      chk("mid_rst_colour", 32'(colour), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      exp_q.delete();
      @(negedge clk);
      chk("rst_hold_plot", 32'(plot), 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_plot", 32'(plot), 32'd0);
      run_cmd(8'd4, 7'd4, 3'b110, 3'b000, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
